// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin packet arbiter: grants one requester per packet, steers the
// 4:1 datapath mux and registers the selected beat into a single-entry output stage.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [3:0]       in_last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       in_ready,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             out_last,
    output logic             overrun
);

    localparam int              CW        = $clog2(MAX_BEATS) + 1;
    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_BUSY   = 1'b1;
    localparam logic [CW-1:0]   CNT_LIMIT = CW'(MAX_BEATS - 1);

    // First requesting port after the previous winner, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    logic [0:0]       state_r;
    logic [1:0]       sel_r;
    logic [1:0]       last_grant_r;
    logic [CW-1:0]    beat_cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [1:0]       out_src_r;
    logic             out_last_r;
    logic             overrun_r;

    logic [WIDTH-1:0] data_mux_s;
    logic [3:0]       in_ready_s;
    logic             xfer_s;
    logic             cap_s;
    logic             eop_s;
    logic             forced_s;
    logic [1:0]       winner_s;

    // Datapath mux driven by the current grant
    always_comb begin
        data_mux_s = {WIDTH{1'b0}};
        case (sel_r)
            2'd0:    data_mux_s = d0;
            2'd1:    data_mux_s = d1;
            2'd2:    data_mux_s = d2;
            2'd3:    data_mux_s = d3;
            default: data_mux_s = {WIDTH{1'b0}};
        endcase
    end

    // Only the granted port may be accepted, and only when the output slot frees up
    always_comb begin
        in_ready_s = 4'b0000;
        if (state_r == ST_BUSY) begin
            in_ready_s[sel_r] = ~out_valid_r | out_ready;
        end else begin
            in_ready_s = 4'b0000;
        end
    end

    assign xfer_s   = in_valid[sel_r] & in_ready_s[sel_r];
    assign cap_s    = (beat_cnt_r == CNT_LIMIT);
    assign eop_s    = xfer_s & (in_last[sel_r] | cap_s);
    assign forced_s = xfer_s & cap_s & ~in_last[sel_r];
    assign winner_s = rr_pick(in_valid, last_grant_r);

    // Grant FSM: arbitrate in IDLE, hold the grant in BUSY until end of packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= 2'd0;
            last_grant_r <= 2'd3;
            beat_cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid != 4'b0000) begin
                        state_r    <= ST_BUSY;
                        sel_r      <= winner_s;
                        beat_cnt_r <= {CW{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + CW'(1);
                        if (eop_s) begin
                            last_grant_r <= sel_r;
                            state_r      <= ST_IDLE;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Single-entry output register; a load and an accept may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_src_r   <= 2'd0;
            out_last_r  <= 1'b0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= data_mux_s;
            out_src_r   <= sel_r;
            out_last_r  <= in_last[sel_r] | cap_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // One-cycle flag for a packet cut short at the beat limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= forced_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign sel       = sel_r;
    assign busy      = (state_r == ST_BUSY);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign out_last  = out_last_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized self-checking bench for mux4_rr_arbiter against a packet-level
// reference model (owner index, beat number within packet, output slot).
module tb_mux4_rr_arbiter;

    localparam int WIDTH     = 32;
    localparam int MAX_BEATS = 16;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [3:0]       in_valid  = 4'b0000;
    logic [3:0]       in_last   = 4'b0000;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] d_s [4];
    logic [3:0]       in_ready;
    logic [1:0]       sel;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_last;
    logic             overrun;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .d0        (d_s[0]),
        .d1        (d_s[1]),
        .d2        (d_s[2]),
        .d3        (d_s[3]),
        .in_ready  (in_ready),
        .sel       (sel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner=-1 means nobody holds the channel
    int               m_owner, m_last, m_beats, m_sel, m_src, m_xsrc;
    bit               m_ov, m_olast, m_ovr, m_xfer;
    logic [WIDTH-1:0] m_data;
    int               n_owner, n_last, n_beats, n_sel, n_src;
    bit               n_ov, n_olast, n_ovr;
    logic [WIDTH-1:0] n_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_beats = 0; m_sel = 0; m_src = 0;
        m_ov = 1'b0; m_olast = 1'b0; m_ovr = 1'b0; m_data = '0;
        m_xfer = 1'b0; m_xsrc = 0;
    endtask

    function automatic logic [3:0] exp_ready();
        if (m_owner < 0) return 4'b0000;
        if (m_ov && !out_ready) return 4'b0000;
        return 4'(1 << m_owner);
    endfunction

    task automatic model_eval();
        bit endp;
        n_owner = m_owner; n_last = m_last; n_beats = m_beats; n_sel = m_sel;
        n_src = m_src; n_ov = m_ov; n_olast = m_olast; n_data = m_data; n_ovr = 1'b0;
        m_xfer = (m_owner >= 0) && in_valid[m_owner] && (!m_ov || out_ready);
        m_xsrc = m_owner;
        endp = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (in_valid[c] && n_owner < 0) begin
                    n_owner = c; n_sel = c; n_beats = 0;
                end
            end
        end else if (m_xfer) begin
            n_beats = m_beats + 1;
            endp = in_last[m_owner] || (n_beats == MAX_BEATS);
            if (endp) begin
                n_last  = m_owner;
                n_owner = -1;
                n_ovr   = !in_last[m_owner];
            end
        end
        if (m_xfer) begin
            n_ov = 1'b1; n_data = d_s[m_owner]; n_src = m_owner; n_olast = endp;
        end else if (m_ov && out_ready) begin
            n_ov = 1'b0;
        end
    endtask

    task automatic model_apply();
        m_owner = n_owner; m_last = n_last; m_beats = n_beats; m_sel = n_sel;
        m_src = n_src; m_ov = n_ov; m_olast = n_olast; m_data = n_data; m_ovr = n_ovr;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) d_s[i] = $urandom;
    endtask

    // Inputs are already applied; check, clock once, check registered outputs
    task automatic run_cycle();
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready()));
        model_eval();
        @(posedge clk);
        #1;
        model_apply();
        check_eq("sel",       32'(sel),       32'(m_sel));
        check_eq("busy",      32'(busy),      32'(m_owner >= 0));
        check_eq("out_valid", 32'(out_valid), 32'(m_ov));
        check_eq("out_data",  out_data,       m_data);
        check_eq("out_src",   32'(out_src),   32'(m_src));
        check_eq("out_last",  32'(out_last),  32'(m_olast));
        check_eq("overrun",   32'(overrun),   32'(m_ovr));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_sel",       32'(sel),       32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_data",  out_data,       32'd0);
        check_eq("rst_out_src",   32'(out_src),   32'd0);
        check_eq("rst_out_last",  32'(out_last),  32'd0);
        check_eq("rst_overrun",   32'(overrun),   32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    int srcs [8];
    int exp_rr [5]   = '{0, 1, 2, 3, 0};
    int exp_fair [4] = '{1, 3, 1, 3};
    logic [WIDTH-1:0] got_d [4];
    bit               got_l [4];
    int nb, nv, k, last_at, ov_cnt, ov_at;
    bit saw0;

    initial begin
        model_reset();
        randomize_data();

        // Reset with every port requesting, then plain rotation 0,1,2,3,0
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        do_reset();
        nb = 0;
        for (int i = 0; i < 14; i++) begin
            randomize_data();
            run_cycle();
            if (out_valid && nb < 5) begin srcs[nb] = int'(out_src); nb++; end
        end
        check_eq("rr_count", 32'(nb), 32'd5);
        for (int i = 0; i < 5; i++) check_eq("rr_order", 32'(srcs[i]), 32'(exp_rr[i]));

        // Fairness between ports 1 and 3 with one-beat packets
        in_valid = 4'b1010; in_last = 4'hF; out_ready = 1'b1;
        do_reset();
        nb = 0; nv = 0;
        for (int i = 0; i < 12; i++) begin
            randomize_data();
            run_cycle();
            if (out_valid) begin
                nv++;
                if (nb < 4) begin srcs[nb] = int'(out_src); nb++; end
            end
        end
        check_eq("fair_beats", 32'(nv), 32'd6);
        for (int i = 0; i < 4; i++) check_eq("fair_order", 32'(srcs[i]), 32'(exp_fair[i]));

        // Port 2 holds the grant for a 4-beat packet while port 0 waits
        do_reset();
        k = 0; nb = 0; saw0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            randomize_data();
            out_ready = 1'b1;
            in_last   = 4'b0001;
            if (i == 0) in_valid = 4'b0100;
            else if (k < 4) in_valid = 4'b0101;
            else in_valid = 4'b0001;
            if (k < 4) begin
                d_s[2] = 32'hA0 + 32'(k);
                in_last[2] = (k == 3);
            end
            run_cycle();
            if (m_xfer && m_xsrc == 2) k++;
            if (out_valid && out_src == 2'd2 && nb < 4) begin
                got_d[nb] = out_data; got_l[nb] = out_last; nb++;
            end
            if (out_valid && out_src == 2'd0 && nb == 4) saw0 = 1'b1;
        end
        check_eq("mb_count", 32'(nb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("mb_data", got_d[i], 32'hA0 + 32'(i));
            check_eq("mb_last", 32'(got_l[i]), 32'(i == 3));
        end
        check_eq("mb_next_port0", 32'(saw0), 32'd1);

        // Backpressure: stall five cycles, then one beat per cycle
        do_reset();
        in_valid = 4'b0001; in_last = 4'b0000; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin randomize_data(); run_cycle(); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin randomize_data(); run_cycle(); end
        out_ready = 1'b1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            randomize_data();
            run_cycle();
            if (out_valid) nv++;
        end
        check_eq("bp_throughput", 32'(nv), 32'd6);

        // Port 1 streams 20 beats without last: forced end at beat 16
        do_reset();
        in_valid = 4'b0010; in_last = 4'b0000; out_ready = 1'b1;
        nb = 0; last_at = 0; ov_cnt = 0; ov_at = 0;
        for (int i = 0; i < 80 && nb < 20; i++) begin
            randomize_data();
            run_cycle();
            if (out_valid) begin
                nb++;
                if (out_last && last_at == 0) last_at = nb;
            end
            if (overrun) begin ov_cnt++; ov_at = nb; end
        end
        check_eq("ovr_beats",   32'(nb),      32'd20);
        check_eq("ovr_last_at", 32'(last_at), 32'(MAX_BEATS));
        check_eq("ovr_pulses",  32'(ov_cnt),  32'd1);
        check_eq("ovr_at",      32'(ov_at),   32'(MAX_BEATS));

        // Reset in the middle of a packet restarts priority at port 0
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b0001; in_last = 4'b0001;
        for (int i = 0; i < 2; i++) begin randomize_data(); run_cycle(); end
        in_valid = 4'b1000; in_last = 4'b0000;
        for (int i = 0; i < 3; i++) begin randomize_data(); run_cycle(); end
        check_eq("mid_pkt_valid", 32'(out_valid), 32'd1);
        do_reset();
        in_valid = 4'b1001;
        randomize_data();
        run_cycle();
        check_eq("rst_prio_sel",  32'(sel),  32'd0);
        check_eq("rst_prio_busy", 32'(busy), 32'd1);

        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            randomize_data();
            in_valid = 4'($urandom);
            for (int b = 0; b < 4; b++) in_last[b] = ($urandom_range(0, 9) < 3);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 399) == 0) do_reset();
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit output channel between four requesters.
- Each requester sends packets as valid/ready beats, with a last flag on the final beat.
- A requester keeps its grant until its packet completes.
- The block drives a 2-bit select for the 4:1 32-bit datapath mux, registers the selected beat into a single-entry output stage, and sits between the peripheral masters and the shared write bus.

Parameters:
- WIDTH, 32: data width of each input and of out_data.
- MAX_BEATS, 16: beat limit per packet. When reached, the packet is force-terminated.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  4  per-requester beat valid; bit i belongs to requester i.
- in_last  in  4  per-requester last-beat flag, qualified by in_valid.
- d0, d1, d2, d3  in  WIDTH each  requester data.
- in_ready  out  4  per-requester beat accept. At most one bit is high.
- sel  out  2  current grant index; drives the 4:1 mux select.
- busy  out  1  a grant is active (state BUSY).
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  registered beat.
- out_src  out  2  requester index of out_data.
- out_last  out  1  beat is the last of its packet (real or forced).
- overrun  out  1  one-cycle pulse when a packet is force-terminated at MAX_BEATS.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, sel=0, busy=0, in_ready=0.
  - out_valid=0, out_data=0, out_src=0, out_last=0, overrun=0.
  - beat_cnt=0, last_grant=3, so requester 0 has first priority.
  - Reset mid-packet discards the packet and the output register.
- States: IDLE, BUSY.
- IDLE:
  - in_ready=0.
  - If any in_valid bit is set, the winner is the first set bit scanning last_grant+1, +2, +3, +4 (mod 4).
  - On the next edge: sel=winner, busy=1, beat_cnt=0, state=BUSY.
  - If no in_valid bit is set, stay in IDLE. sel holds its last value.
- BUSY:
  - in_ready[sel] = (!out_valid || out_ready). All other in_ready bits are 0.
  - A beat transfers when in_valid[sel] && in_ready[sel].
  - On transfer: out_data <= d[sel], out_src <= sel, out_valid <= 1, beat_cnt <= beat_cnt+1.
  - out_last <= in_last[sel] || (beat_cnt == MAX_BEATS-1).
  - End of packet is a transfer where in_last[sel]=1 or beat_cnt == MAX_BEATS-1.
  - At end of packet: last_grant <= sel, state <= IDLE, busy <= 0 on the next edge.
  - If the end is forced (in_last=0 at the MAX_BEATS-th beat): overrun=1 for exactly that next cycle. Later beats from the same requester arbitrate as a new packet.
  - in_valid[sel] dropping mid-packet stalls in BUSY; the grant is never released without an end-of-packet.
  - Requests from other ports have no effect while BUSY.
- Output stage:
  - If out_valid && out_ready and there is no new transfer, out_valid <= 0 and the data/src/last fields hold.
  - An accept and a load in the same cycle is legal: the new beat replaces the old one, giving full throughput.
  - out_data, out_src and out_last are stable while out_valid && !out_ready.
- Latency:
  - in_valid rises at edge N, so the grant is visible after edge N+1.
  - The first beat is accepted in cycle N+1 if the output is free, and out_valid=1 after edge N+2.
  - One IDLE bubble cycle between consecutive packets.
- Width rules:
  - beat_cnt is clog2(MAX_BEATS)+1 bits.
  - sel, out_src and last_grant wrap mod 4.

Test Plan:
- Reset check: hold rst_n=0 with all in_valid=1 -> all outputs 0 and in_ready=0. Release rst_n -> grant goes to requester 0 (sel=0), then 1, 2, 3, 0 over successive single-beat packets with in_last=1.
- Fairness: requesters 1 and 3 request continuously with 1-beat packets, out_ready=1 -> out_src sequence 1,3,1,3. One bubble cycle between beats. No starvation.
- Multi-beat hold: requester 2 sends 4 beats 0xA0..0xA3 with last on the 4th while requester 0 also requests -> out_data A0,A1,A2,A3 from src 2 contiguously, out_last only on A3, then the grant moves to 0.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and out_data frozen. Release -> throughput of one beat per cycle.
- Overrun: MAX_BEATS=16, requester 1 streams 20 beats with no last -> beat 16 has out_last=1, overrun pulses once, and beats 17-20 form a re-arbitrated packet.
- Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat packet -> out_valid drops immediately. After release, state is IDLE and priority restarts at requester 0.
